// File: rtl/dcache_ram_bridge_pkg.sv
// Shared constants and types for the dcache <-> RAMHelper bridge.
package dcache_ram_bridge_pkg;

  // Access size encodings on cmd_size
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  // Reset PC and RAM base share the same physical address
  localparam logic [63:0] PC_START = 64'h8000_0000;
  localparam logic [63:0] RAM_BASE = PC_START;

  // Privilege modes
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [0:0] {StRst, StRun} bridge_state_e;

  // Byte strobes to a per-bit write mask
  function automatic logic [63:0] expand_strb(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dcache_addr_check.sv
// Combinational address check: range/size/alignment fault, word index and write mask.
module dcache_addr_check
  import dcache_ram_bridge_pkg::*;
#(
  parameter logic [63:0] BASE      = RAM_BASE,
  parameter int unsigned SIZE_LOG2 = 31,
  parameter int unsigned IDX_W     = SIZE_LOG2 - 3
) (
  input  logic [63:0]      addr_i,
  input  logic [2:0]       size_i,
  input  logic [7:0]       wstrb_i,
  output logic             fault_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [63:0]      wmask_o
);

  logic [63:0] off;
  logic [2:0]  align_mask;
  logic        size_bad;
  logic        in_range;
  logic        misaligned;

  // Decode size, then combine the three fault sources
  always_comb begin
    off        = addr_i - BASE;
    align_mask = 3'd0;
    size_bad   = 1'b0;
    case (size_i)
      SZ_B:    align_mask = 3'd0;
      SZ_H:    align_mask = 3'd1;
      SZ_W:    align_mask = 3'd3;
      SZ_D:    align_mask = 3'd7;
      default: size_bad   = 1'b1;
    endcase
    in_range   = (addr_i >= BASE) && ((off >> SIZE_LOG2) == 64'd0);
    misaligned = (addr_i[2:0] & align_mask) != 3'd0;
    fault_o    = ~in_range | size_bad | misaligned;
    idx_o      = off[SIZE_LOG2-1:3];
    wmask_o    = expand_strb(wstrb_i);
  end

endmodule

// File: rtl/dcache_ram_bridge.sv
// Bridge from the dcache cmd/rsp port to the RAMHelper data side.
module dcache_ram_bridge
  import dcache_ram_bridge_pkg::*;
#(
  parameter logic [63:0] BASE      = RAM_BASE,
  parameter int unsigned SIZE_LOG2 = 31,
  parameter int unsigned IDX_W     = SIZE_LOG2 - 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_addr,
  input  logic             cmd_wen,
  input  logic [63:0]      cmd_wdata,
  input  logic [7:0]       cmd_wstrb,
  input  logic [2:0]       cmd_size,
  output logic             rsp_valid,
  output logic [63:0]      rsp_data,
  output logic             rsp_err,
  output logic             ram_en,
  output logic [IDX_W-1:0] ram_ridx,
  input  logic [63:0]      ram_rdata,
  output logic [IDX_W-1:0] ram_widx,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask,
  output logic             ram_wen,
  output logic             err_sticky,
  output logic [63:0]      err_addr,
  output logic [31:0]      ld_cnt,
  output logic [31:0]      st_cnt
);

  bridge_state_e state_q, state_d;

  logic             fault;
  logic [IDX_W-1:0] idx;
  logic [63:0]      wmask;
  logic             acc, good, good_ld, good_st;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        err_sticky_q;
  logic [63:0] err_addr_q;
  logic [31:0] ld_cnt_q, st_cnt_q;

  dcache_addr_check #(
    .BASE      (BASE),
    .SIZE_LOG2 (SIZE_LOG2),
    .IDX_W     (IDX_W)
  ) u_addr_check (
    .addr_i  (cmd_addr),
    .size_i  (cmd_size),
    .wstrb_i (cmd_wstrb),
    .fault_o (fault),
    .idx_o   (idx),
    .wmask_o (wmask)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StRst;
    else       state_q <= state_d;
  end

  // FSM next state: one idle cycle after reset, then run until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:   state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StRst;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (state_q == StRun);
  end

  // Accept qualification and RAM-side drive; index/data/mask are zero when idle
  always_comb begin
    acc       = cmd_valid & cmd_ready;
    good      = acc & ~fault;
    good_ld   = good & ~cmd_wen;
    good_st   = good & cmd_wen & (cmd_wstrb != 8'd0);
    ram_en    = good;
    ram_wen   = good_st;
    ram_ridx  = acc ? idx : '0;
    ram_widx  = acc ? idx : '0;
    ram_wdata = acc ? cmd_wdata : '0;
    ram_wmask = acc ? wmask : '0;
  end

  // Response next state: loads and faults answer, good stores are silent
  always_comb begin
    rsp_valid_d = good_ld | (acc & fault);
    rsp_err_d   = acc & fault;
    rsp_data_d  = good_ld ? ram_rdata : 64'd0;
  end

  // Response, sticky error capture and access counters
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
      ld_cnt_q     <= '0;
      st_cnt_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      if (acc && fault && !err_sticky_q) begin
        err_sticky_q <= 1'b1;
        err_addr_q   <= cmd_addr;
      end
      if (good_ld) ld_cnt_q <= ld_cnt_q + 32'd1;
      if (good_st) st_cnt_q <= st_cnt_q + 32'd1;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;
  assign ld_cnt     = ld_cnt_q;
  assign st_cnt     = st_cnt_q;

endmodule

// File: tb/tb_dcache_ram_bridge.sv
// Self-checking bench for dcache_ram_bridge with a small RAM model and response scoreboard.
module tb_dcache_ram_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wen;
  logic [63:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_data;
  logic        ram_en, ram_wen;
  logic [27:0] ram_ridx, ram_widx;
  logic [63:0] ram_rdata, ram_wdata, ram_wmask;
  logic        err_sticky;
  logic [63:0] err_addr;
  logic [31:0] ld_cnt, st_cnt;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  dcache_ram_bridge u_dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wen    (cmd_wen),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .cmd_size   (cmd_size),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ram_en     (ram_en),
    .ram_ridx   (ram_ridx),
    .ram_rdata  (ram_rdata),
    .ram_widx   (ram_widx),
    .ram_wdata  (ram_wdata),
    .ram_wmask  (ram_wmask),
    .ram_wen    (ram_wen),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .ld_cnt     (ld_cnt),
    .st_cnt     (st_cnt)
  );

  // RAMHelper stand-in: 256 words, combinational read, masked write at the edge
  logic [63:0] mem [256];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
    end else if (ram_wen) begin
      mem[ram_widx[7:0]] <= (mem[ram_widx[7:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end
  always_comb ram_rdata = mem[ram_ridx[7:0]];

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past 500000 time units, required completion");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic w,
                       input logic [63:0] d, input logic [7:0] s, input logic [2:0] z);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_wen   = w;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_size  = z;
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 3'd0);
  endtask

  // Scoreboard consumer: every rsp_valid pulse must match the oldest expectation
  task automatic rsp_monitor();
    rsp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rsp_unexpected: got err=%0b data=%h, required no response", rsp_err,
                   rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_data} !== {e.err, e.data}) begin
            n_errors++;
            $display("FAIL rsp_compare: got err=%0b data=%h, required err=%0b data=%h", rsp_err,
                     rsp_data, e.err, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) next_cycle();
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL ready_in_reset: got %0b, required 0", cmd_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 66'd0) begin
      n_errors++;
      $display("FAIL rsp_in_reset: got v=%0b e=%0b d=%h, required all 0", rsp_valid, rsp_err,
               rsp_data);
    end
    n_checks++;
    if ({err_sticky, err_addr, ld_cnt, st_cnt} !== 129'd0) begin
      n_errors++;
      $display("FAIL debug_in_reset: got sticky=%0b addr=%h ld=%0d st=%0d, required all 0",
               err_sticky, err_addr, ld_cnt, st_cnt);
    end
    n_checks++;
    if ({ram_en, ram_wen, ram_ridx, ram_widx, ram_wdata, ram_wmask} !== 186'd0) begin
      n_errors++; $display("FAIL ram_in_reset: got nonzero ram_* outputs, required all 0");
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL ready_rst_state: got %0b, required 0", cmd_ready);
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL ready_run_state: got %0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_store_load();
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 3'd3);
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_wen, ram_widx, ram_wmask} !== {1'b1, 1'b1, 28'd2, 64'hFFFF_FFFF_FFFF_FFFF})
    begin
      n_errors++;
      $display("FAIL store_d_ram: got en=%0b wen=%0b widx=%0h mask=%h, required 1 1 2 all-ones",
               ram_en, ram_wen, ram_widx, ram_wmask);
    end
    n_checks++;
    if (ram_wdata !== 64'h1122_3344_5566_7788) begin
      n_errors++; $display("FAIL store_d_wdata: got %h, required 1122334455667788", ram_wdata);
    end
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, 3'd3);
    exp_q.push_back('{err: 1'b0, data: 64'h1122_3344_5566_7788});
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_wen, ram_ridx} !== {1'b1, 1'b0, 28'd2}) begin
      n_errors++;
      $display("FAIL load_d_ram: got en=%0b wen=%0b ridx=%0h, required 1 0 2", ram_en, ram_wen,
               ram_ridx);
    end
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({st_cnt, ld_cnt} !== {32'd1, 32'd1}) begin
      n_errors++; $display("FAIL cnt_after_sl: got st=%0d ld=%0d, required 1 1", st_cnt, ld_cnt);
    end
  endtask

  task automatic test_byte_store();
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b1, 64'd0, 8'hFF, 3'd3);
    next_cycle();
    drive(1'b1, 64'h8000_0013, 1'b1, 64'h0000_0000_AB00_0000, 8'h08, 3'd0);
    @(negedge clock);
    n_checks++;
    if ({ram_wen, ram_wmask} !== {1'b1, 64'h0000_0000_FF00_0000}) begin
      n_errors++;
      $display("FAIL byte_mask: got wen=%0b mask=%h, required 1 00000000ff000000", ram_wen,
               ram_wmask);
    end
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, 3'd3);
    exp_q.push_back('{err: 1'b0, data: 64'h0000_0000_AB00_0000});
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'd3);
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_wen} !== 2'b10) begin
      n_errors++;
      $display("FAIL zero_strb: got en=%0b wen=%0b, required 1 0", ram_en, ram_wen);
    end
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, 3'd3);
    exp_q.push_back('{err: 1'b0, data: 64'h0000_0000_AB00_0000});
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({st_cnt, ld_cnt, err_sticky} !== {32'd3, 32'd3, 1'b0}) begin
      n_errors++;
      $display("FAIL cnt_after_byte: got st=%0d ld=%0d sticky=%0b, required 3 3 0", st_cnt,
               ld_cnt, err_sticky);
    end
  endtask

  task automatic test_misaligned();
    next_cycle();
    drive(1'b1, 64'h8000_0006, 1'b0, 64'd0, 8'd0, 3'd2);
    exp_q.push_back('{err: 1'b1, data: 64'd0});
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_wen} !== 2'b00) begin
      n_errors++;
      $display("FAIL misalign_ram: got en=%0b wen=%0b, required 0 0", ram_en, ram_wen);
    end
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({err_sticky, err_addr} !== {1'b1, 64'h8000_0006}) begin
      n_errors++;
      $display("FAIL misalign_sticky: got sticky=%0b addr=%h, required 1 80000006", err_sticky,
               err_addr);
    end
    // Illegal size at an aligned address: faults, but the first capture is kept
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, 3'd5);
    exp_q.push_back('{err: 1'b1, data: 64'd0});
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({err_addr, ld_cnt} !== {64'h8000_0006, 32'd3}) begin
      n_errors++;
      $display("FAIL bad_size_hold: got addr=%h ld=%0d, required 80000006 3", err_addr, ld_cnt);
    end
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    idle();
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 64'h7FFF_FFF8, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 3'd3);
    exp_q.push_back('{err: 1'b1, data: 64'd0});
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_wen} !== 2'b00) begin
      n_errors++;
      $display("FAIL below_base_ram: got en=%0b wen=%0b, required 0 0", ram_en, ram_wen);
    end
    next_cycle();
    drive(1'b1, 64'h1_0000_0000, 1'b0, 64'd0, 8'd0, 3'd3);
    exp_q.push_back('{err: 1'b1, data: 64'd0});
    @(negedge clock);
    n_checks++;
    if (ram_en !== 1'b0) begin
      n_errors++; $display("FAIL above_top_ram: got en=%0b, required 0", ram_en);
    end
    next_cycle();
    drive(1'b1, 64'hFFFF_FFF8, 1'b0, 64'd0, 8'd0, 3'd3);
    exp_q.push_back('{err: 1'b0, data: 64'd0});
    @(negedge clock);
    n_checks++;
    if ({ram_en, ram_ridx} !== {1'b1, 28'hFFF_FFFF}) begin
      n_errors++;
      $display("FAIL last_word: got en=%0b ridx=%0h, required 1 fffffff", ram_en, ram_ridx);
    end
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({err_sticky, err_addr, st_cnt, ld_cnt} !== {1'b1, 64'h7FFF_FFF8, 32'd0, 32'd1}) begin
      n_errors++;
      $display("FAIL range_debug: got sticky=%0b addr=%h st=%0d ld=%0d, required 1 7ffffff8 0 1",
               err_sticky, err_addr, st_cnt, ld_cnt);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive(1'b1, 64'h8000_0010, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 3'd3);
    next_cycle();
    // Load accepted on the same edge that samples reset: its response is dropped
    drive(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'd0, 3'd3);
    reset = 1'b1;
    next_cycle();
    idle();
    @(negedge clock);
    n_checks++;
    if ({rsp_valid, ld_cnt, st_cnt, err_sticky} !== 66'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got v=%0b ld=%0d st=%0d sticky=%0b, required all 0", rsp_valid,
               ld_cnt, st_cnt, err_sticky);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_mid_after: got v=%0b ready=%0b, required 0 0", rsp_valid, cmd_ready);
    end
    repeat (2) next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    fork
      rsp_monitor();
    join_none
    test_reset();
    test_store_load();
    test_byte_store();
    test_misaligned();
    do_reset();
    test_out_of_range();
    test_reset_mid();
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rsp_missing: got %0d outstanding expected responses, required 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
